// File: rtl/wb_map_pkg.sv
// 3DO address map shared by the Wishbone bridge and the core's chip-select logic:
// region codes, window bounds and the bridge FSM state type.
package wb_map_pkg;

  localparam logic [2:0] REGION_DRAM  = 3'd0;
  localparam logic [2:0] REGION_VRAM  = 3'd1;
  localparam logic [2:0] REGION_BIOS  = 3'd2;
  localparam logic [2:0] REGION_NVRAM = 3'd3;
  localparam logic [2:0] REGION_XBUS  = 3'd4;

  localparam logic [31:0] DRAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] DRAM_LIMIT = 32'h001F_FFFF;
  localparam logic [31:0] VRAM_BASE  = 32'h0020_0000;
  localparam logic [31:0] VRAM_LIMIT = 32'h002F_FFFF;
  localparam logic [31:0] BIOS_BASE  = 32'h0300_0000;
  localparam logic [31:0] BIOS_LIMIT = 32'h030F_FFFF;
  localparam logic [31:0] NVRAM_BASE  = 32'h0314_0000;
  localparam logic [31:0] NVRAM_LIMIT = 32'h0317_FFFF;
  localparam logic [31:0] REG_BASE   = 32'h0330_0000;
  localparam logic [31:0] REG_LIMIT  = 32'h0340_FFFF;
  localparam logic [31:0] XBUS_PORT  = 32'h0340_0414;
  localparam logic [31:0] XBUS_BASE  = 32'h0340_0500;
  localparam logic [31:0] XBUS_LIMIT = 32'h0340_05FF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM,
    ST_REG,
    ST_ACK
  } state_t;

  // Offset form keeps the zero-based DRAM window free of an always-true compare.
  function automatic logic in_window(input logic [31:0] adr,
                                     input logic [31:0] base,
                                     input logic [31:0] limit);
    return (adr - base) <= (limit - base);
  endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational 3DO address decoder; first matching window wins, XBUS ports
// being carved out of the MADAM/CLIO register window.
module wb_addr_decode
  import wb_map_pkg::*;
(
  input  logic [31:0] adr,
  output logic [2:0]  region,
  output logic        is_reg,
  output logic        is_unmapped,
  output logic        is_rom
);

  always_comb begin
    region      = REGION_DRAM;
    is_reg      = 1'b0;
    is_unmapped = 1'b0;
    is_rom      = 1'b0;
    if (adr == XBUS_PORT || in_window(adr, XBUS_BASE, XBUS_LIMIT)) begin
      region = REGION_XBUS;
    end else if (in_window(adr, REG_BASE, REG_LIMIT)) begin
      is_reg = 1'b1;
    end else if (in_window(adr, DRAM_BASE, DRAM_LIMIT)) begin
      region = REGION_DRAM;
    end else if (in_window(adr, VRAM_BASE, VRAM_LIMIT)) begin
      region = REGION_VRAM;
    end else if (in_window(adr, BIOS_BASE, BIOS_LIMIT)) begin
      region = REGION_BIOS;
      is_rom = 1'b1;
    end else if (in_window(adr, NVRAM_BASE, NVRAM_LIMIT)) begin
      region = REGION_NVRAM;
    end else begin
      is_unmapped = 1'b1;
    end
  end

endmodule

// File: rtl/wb_mem_bridge.sv
// Wishbone classic slave bridging the core bus to the memory model with a single
// outstanding request, register/unmapped self-ack and a timeout watchdog.
module wb_mem_bridge
  import wb_map_pkg::*;
#(
  parameter int unsigned REG_WAIT = 1,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] TO_DATA  = 32'hDEADBEEF
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_w,
  input  logic [3:0]  wb_sel,
  input  logic        wb_we,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  output logic [31:0] wb_dat_r,
  output logic        wb_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mem_region,
  output logic [21:0] mem_addr,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_wdat,
  input  logic [31:0] mem_rdat,
  input  logic        mem_rdy,
  output logic        err_timeout,
  output logic        err_unmapped,
  input  logic        err_clr
);

  localparam logic [15:0] REG_LOAD = 16'(REG_WAIT);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        abort_q, abort_d;
  logic        start, set_to, set_um, bus_req;

  logic [2:0]  dec_region;
  logic        dec_is_reg, dec_is_unmapped, dec_is_rom;

  wb_addr_decode u_decode (
    .adr         (wb_adr),
    .region      (dec_region),
    .is_reg      (dec_is_reg),
    .is_unmapped (dec_is_unmapped),
    .is_rom      (dec_is_rom)
  );

  assign bus_req  = wb_cyc & wb_stb;
  assign mem_req  = (state_q == ST_MEM);
  // An abandoned cycle still runs to completion but never acks.
  assign wb_ack   = (state_q == ST_ACK) & ~abort_q & bus_req;
  assign wb_dat_r = wb_ack ? rdata_q : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    abort_d = abort_q;
    start   = 1'b0;
    set_to  = 1'b0;
    set_um  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus_req && !wb_ack) begin
          start   = 1'b1;
          abort_d = 1'b0;
          rdata_d = '0;
          cnt_d   = '0;
          if (dec_is_unmapped) begin
            set_um  = 1'b1;
            state_d = ST_ACK;
          end else if (dec_is_reg) begin
            if (REG_WAIT == 0) begin
              state_d = ST_ACK;
            end else begin
              cnt_d   = REG_LOAD;
              state_d = ST_REG;
            end
          end else if (dec_is_rom && wb_we) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_MEM;
          end
        end
      end
      ST_MEM: begin
        if (mem_rdy) begin
          rdata_d = mem_we ? '0 : mem_rdat;
          state_d = ST_ACK;
        end else if (cnt_q == TO_LAST) begin
          rdata_d = TO_DATA;
          set_to  = 1'b1;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_REG: begin
        // Leaving on the count-to-zero edge makes REG_WAIT the exact number of REG cycles.
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && !bus_req) abort_d = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rdata_q      <= '0;
      abort_q      <= 1'b0;
      err_timeout  <= 1'b0;
      err_unmapped <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      abort_q      <= abort_d;
      err_timeout  <= set_to | (err_timeout & ~err_clr);
      err_unmapped <= set_um | (err_unmapped & ~err_clr);
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we     <= 1'b0;
      mem_region <= '0;
      mem_addr   <= '0;
      mem_sel    <= '0;
      mem_wdat   <= '0;
    end else if (start) begin
      mem_we     <= wb_we;
      mem_region <= dec_region;
      mem_addr   <= wb_adr[23:2];
      mem_sel    <= wb_sel;
      mem_wdat   <= wb_dat_w;
    end
  end

endmodule

// File: tb/tb_wb_mem_bridge.sv
// Bench for wb_mem_bridge: hand-filled vector table, multi-cycle corner sequences,
// then randomized transactions against an address-map/latency reference model.
module tb_wb_mem_bridge;

  localparam int unsigned REG_WAIT = 1;
  localparam int unsigned TIMEOUT  = 8;
  localparam logic [31:0] TO_DATA  = 32'hDEADBEEF;
  localparam int unsigned K_REG = 5;
  localparam int unsigned K_UNM = 6;
  localparam int unsigned NEVER = 255;

  logic        sys_clk, reset_n;
  logic [31:0] wb_adr, wb_dat_w, wb_dat_r, mem_wdat, mem_rdat;
  logic [3:0]  wb_sel, mem_sel;
  logic        wb_we, wb_cyc, wb_stb, wb_ack;
  logic        mem_req, mem_we, mem_rdy;
  logic [2:0]  mem_region;
  logic [21:0] mem_addr;
  logic        err_timeout, err_unmapped, err_clr;

  wb_mem_bridge #(.REG_WAIT(REG_WAIT), .TIMEOUT(TIMEOUT), .TO_DATA(TO_DATA)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_sel(wb_sel), .wb_we(wb_we),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_dat_r(wb_dat_r), .wb_ack(wb_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_region(mem_region), .mem_addr(mem_addr),
    .mem_sel(mem_sel), .mem_wdat(mem_wdat), .mem_rdat(mem_rdat), .mem_rdy(mem_rdy),
    .err_timeout(err_timeout), .err_unmapped(err_unmapped), .err_clr(err_clr)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] adr; logic we; logic [3:0] sel; logic [31:0] dat;
    int unsigned rdy_dly; logic [31:0] rdat;
    logic exp_req; logic [2:0] exp_region; logic [21:0] exp_addr;
    int unsigned exp_edges; logic [31:0] exp_data; logic exp_um; logic exp_to;
  } vec_t;

  typedef struct {
    logic ack; logic [31:0] data; int unsigned edges; logic saw_req;
    logic [2:0] region; logic [21:0] addr; logic we; logic [3:0] sel;
    logic [31:0] wdat; logic stable;
  } obs_t;

  vec_t vt[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model straight from the address map and latency rules.
  function automatic int unsigned ref_kind(input logic [31:0] a);
    if (a == 32'h0340_0414 || (a >= 32'h0340_0500 && a <= 32'h0340_05FF)) return 4;
    if (a >= 32'h0330_0000 && a <= 32'h0340_FFFF) return K_REG;
    if (a <= 32'h001F_FFFF) return 0;
    if (a >= 32'h0020_0000 && a <= 32'h002F_FFFF) return 1;
    if (a >= 32'h0300_0000 && a <= 32'h030F_FFFF) return 2;
    if (a >= 32'h0314_0000 && a <= 32'h0317_FFFF) return 3;
    return K_UNM;
  endfunction

  function automatic logic ref_req(input int unsigned k, input logic we);
    return (k < K_REG) && !(k == 2 && we);
  endfunction

  function automatic int unsigned ref_edges(input int unsigned k, input logic we,
                                            input int unsigned dly);
    if (!ref_req(k, we)) return (k == K_REG) ? 1 + REG_WAIT : 1;
    return (dly < TIMEOUT) ? 2 + dly : 1 + TIMEOUT;
  endfunction

  function automatic logic [31:0] ref_data(input int unsigned k, input logic we,
                                           input int unsigned dly, input logic [31:0] rdat);
    if (!ref_req(k, we)) return 32'h0;
    if (dly >= TIMEOUT) return TO_DATA;
    return we ? 32'h0 : rdat;
  endfunction

  // One Wishbone cycle with a memory responder that raises mem_rdy in req cycle rdy_dly.
  task automatic do_txn(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                        input logic [31:0] dat, input int unsigned rdy_dly,
                        input logic [31:0] rdat, output obs_t o);
    int unsigned reqc;
    reqc = 0;
    o.ack = 0; o.data = '0; o.edges = 0; o.saw_req = 0; o.region = '0; o.addr = '0;
    o.we = 0; o.sel = '0; o.wdat = '0; o.stable = 1;
    @(negedge sys_clk);
    wb_adr = adr; wb_we = we; wb_sel = sel; wb_dat_w = dat; wb_cyc = 1; wb_stb = 1;
    while (1'b1) begin
      if (wb_ack) begin o.ack = 1; o.data = wb_dat_r; break; end
      if (o.edges >= 40) break;
      if (mem_req) begin
        if (!o.saw_req) begin
          o.region = mem_region; o.addr = mem_addr; o.we = mem_we; o.sel = mem_sel;
          o.wdat = mem_wdat;
        end else if ({mem_region, mem_addr, mem_we, mem_sel, mem_wdat} !=
                     {o.region, o.addr, o.we, o.sel, o.wdat}) begin
          o.stable = 0;
        end
        o.saw_req = 1;
        mem_rdy  = (reqc == rdy_dly);
        mem_rdat = (reqc == rdy_dly) ? rdat : $urandom;
        reqc++;
      end else begin
        mem_rdy  = 1'($urandom);
        mem_rdat = $urandom;
      end
      @(posedge sys_clk);
      o.edges++;
      @(negedge sys_clk);
    end
    wb_cyc = 0; wb_stb = 0; mem_rdy = 0;
  endtask

  task automatic verify(input string tag, input obs_t o, input logic exp_req,
                        input logic [2:0] exp_region, input logic [21:0] exp_addr,
                        input logic we, input logic [3:0] sel, input logic [31:0] dat,
                        input int unsigned exp_edges, input logic [31:0] exp_data,
                        input logic exp_um, input logic exp_to);
    chk({tag, ".ack"}, 32'(o.ack), 32'd1);
    chk({tag, ".edges"}, o.edges, exp_edges);
    chk({tag, ".data"}, o.data, exp_data);
    chk({tag, ".req"}, 32'(o.saw_req), 32'(exp_req));
    if (exp_req) begin
      chk({tag, ".region"}, 32'(o.region), 32'(exp_region));
      chk({tag, ".addr"}, 32'(o.addr), 32'(exp_addr));
      chk({tag, ".we"}, 32'(o.we), 32'(we));
      chk({tag, ".sel"}, 32'(o.sel), 32'(sel));
      chk({tag, ".wdat"}, o.wdat, dat);
      chk({tag, ".stable"}, 32'(o.stable), 32'd1);
    end
    chk({tag, ".err_um"}, 32'(err_unmapped), 32'(exp_um));
    chk({tag, ".err_to"}, 32'(err_timeout), 32'(exp_to));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    obs_t o;
    logic [31:0] rlo[9];
    logic [31:0] rsz[9];
    logic m_um, m_to, wv;
    int unsigned k, dly, acks, reqc;
    logic [31:0] a, d, rd;
    logic [3:0] s;

    vt[0]  = '{32'h0000_1000, 1'b0, 4'hF, 32'h0,         2,     32'h1234_5678, 1'b1, 3'd0, 22'h000400, 4, 32'h1234_5678, 1'b0, 1'b0};
    vt[1]  = '{32'h0020_0004, 1'b1, 4'h3, 32'hAABB_CCDD, 0,     32'h0,         1'b1, 3'd1, 22'h080001, 2, 32'h0,         1'b0, 1'b0};
    vt[2]  = '{32'h0300_0010, 1'b1, 4'hF, 32'h1111_1111, 0,     32'h0,         1'b0, 3'd0, 22'h0,      1, 32'h0,         1'b0, 1'b0};
    vt[3]  = '{32'h0300_0010, 1'b0, 4'hF, 32'h0,         1,     32'hCAFE_F00D, 1'b1, 3'd2, 22'h000004, 3, 32'hCAFE_F00D, 1'b0, 1'b0};
    vt[4]  = '{32'h0330_0000, 1'b0, 4'hF, 32'h0,         0,     32'h0,         1'b0, 3'd0, 22'h0,      2, 32'h0,         1'b0, 1'b0};
    vt[5]  = '{32'h0340_0414, 1'b0, 4'hF, 32'h0,         0,     32'h0BAD_F00D, 1'b1, 3'd4, 22'h100105, 2, 32'h0BAD_F00D, 1'b0, 1'b0};
    vt[6]  = '{32'h0340_05FC, 1'b1, 4'hC, 32'h0102_0304, 3,     32'h0,         1'b1, 3'd4, 22'h10017F, 5, 32'h0,         1'b0, 1'b0};
    vt[7]  = '{32'h0340_0418, 1'b0, 4'hF, 32'h0,         0,     32'h0,         1'b0, 3'd0, 22'h0,      2, 32'h0,         1'b0, 1'b0};
    vt[8]  = '{32'h0314_0000, 1'b0, 4'hF, 32'h0,         0,     32'h1357_9BDF, 1'b1, 3'd3, 22'h050000, 2, 32'h1357_9BDF, 1'b0, 1'b0};
    vt[9]  = '{32'h001F_FFFC, 1'b0, 4'hF, 32'h0,         1,     32'h2468_ACE0, 1'b1, 3'd0, 22'h07FFFF, 3, 32'h2468_ACE0, 1'b0, 1'b0};
    vt[10] = '{32'h0000_1004, 1'b0, 4'hF, 32'h0,         7,     32'h5A5A_5A5A, 1'b1, 3'd0, 22'h000401, 9, 32'h5A5A_5A5A, 1'b0, 1'b0};
    vt[11] = '{32'h0340_FFFC, 1'b0, 4'hF, 32'h0,         0,     32'h0,         1'b0, 3'd0, 22'h0,      2, 32'h0,         1'b0, 1'b0};
    vt[12] = '{32'h0500_0000, 1'b0, 4'hF, 32'h0,         0,     32'h0,         1'b0, 3'd0, 22'h0,      1, 32'h0,         1'b1, 1'b0};
    vt[13] = '{32'h0310_0000, 1'b0, 4'hF, 32'h0,         0,     32'h0,         1'b0, 3'd0, 22'h0,      1, 32'h0,         1'b1, 1'b0};
    vt[14] = '{32'h0000_0008, 1'b0, 4'hF, 32'h0,         NEVER, 32'h0,         1'b1, 3'd0, 22'h000002, 9, TO_DATA,       1'b1, 1'b1};

    reset_n = 0; err_clr = 0; wb_adr = '0; wb_dat_w = '0; wb_sel = '0; wb_we = 0;
    wb_cyc = 0; wb_stb = 0; mem_rdat = '0; mem_rdy = 0;
    repeat (2) @(negedge sys_clk);
    chk("reset.outputs", {wb_dat_r[15:0], 5'(0), wb_ack, mem_req, mem_we, mem_region, err_timeout, err_unmapped},
        32'h0);
    chk("reset.mem_bus", {mem_addr[15:0], mem_sel, mem_wdat[11:0]}, 32'h0);
    reset_n = 1;

    foreach (vt[i])
      begin
        do_txn(vt[i].adr, vt[i].we, vt[i].sel, vt[i].dat, vt[i].rdy_dly, vt[i].rdat, o);
        verify($sformatf("vec%0d", i), o, vt[i].exp_req, vt[i].exp_region, vt[i].exp_addr,
               vt[i].we, vt[i].sel, vt[i].dat, vt[i].exp_edges, vt[i].exp_data,
               vt[i].exp_um, vt[i].exp_to);
      end

    // err_clr clears both sticky flags.
    @(negedge sys_clk); err_clr = 1;
    @(negedge sys_clk); err_clr = 0;
    chk("clr.err_um", 32'(err_unmapped), 32'd0);
    chk("clr.err_to", 32'(err_timeout), 32'd0);

    // Unmapped access while err_clr is held: the set wins.
    err_clr = 1;
    do_txn(32'h0600_0000, 1'b0, 4'hF, 32'h0, 0, 32'h0, o);
    chk("setwins.ack", 32'(o.ack), 32'd1);
    chk("setwins.err_um", 32'(err_unmapped), 32'd1);
    chk("setwins.err_to", 32'(err_timeout), 32'd0);
    err_clr = 0;

    // mem_rdy while idle is ignored.
    acks = 0;
    mem_rdy = 1; mem_rdat = 32'hFFFF_FFFF;
    repeat (4) begin @(negedge sys_clk); acks += 32'(wb_ack) + 32'(mem_req); end
    mem_rdy = 0;
    chk("idle_rdy.quiet", acks, 0);

    // Strobe withdrawn after the request: memory completes, no ack.
    @(negedge sys_clk);
    wb_adr = 32'h0000_2000; wb_we = 0; wb_sel = 4'hF; wb_cyc = 1; wb_stb = 1;
    @(posedge sys_clk); @(negedge sys_clk);
    wb_cyc = 0; wb_stb = 0;
    acks = 0; reqc = 0;
    repeat (10) begin
      if (mem_req) begin mem_rdy = (reqc == 2); mem_rdat = 32'h7777_7777; reqc++; end
      else mem_rdy = 0;
      acks += 32'(wb_ack);
      @(posedge sys_clk); @(negedge sys_clk);
    end
    mem_rdy = 0;
    chk("abort.no_ack", acks, 0);
    chk("abort.req_cycles", reqc, 3);

    // Randomized transactions against the reference model.
    rlo = '{32'h0000_0000, 32'h0020_0000, 32'h0300_0000, 32'h0314_0000, 32'h0330_0000,
            32'h0340_0414, 32'h0340_0500, 32'h0400_0000, 32'h0310_0000};
    rsz = '{32'h0020_0000, 32'h0010_0000, 32'h0010_0000, 32'h0004_0000, 32'h0011_0000,
            32'h0000_0004, 32'h0000_0100, 32'h0100_0000, 32'h0004_0000};
    m_um = 1; m_to = 0;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(negedge sys_clk); err_clr = 1;
        @(negedge sys_clk); err_clr = 0;
        m_um = 0; m_to = 0;
      end
      k   = $urandom_range(0, 8);
      a   = rlo[k] + (($urandom % rsz[k]) & 32'hFFFF_FFFC);
      wv  = 1'($urandom);
      s   = 4'($urandom);
      d   = $urandom;
      rd  = $urandom;
      dly = $urandom_range(0, 9);
      do_txn(a, wv, s, d, dly, rd, o);
      k = ref_kind(a);
      m_um = m_um | (k == K_UNM);
      m_to = m_to | (ref_req(k, wv) && dly >= TIMEOUT);
      verify($sformatf("rnd%0d@%08h", n, a), o, ref_req(k, wv), 3'(k), a[23:2], wv, s, d,
             ref_edges(k, wv, dly), ref_data(k, wv, dly, rd), m_um, m_to);
    end

    // Asynchronous reset in the middle of a memory cycle.
    @(negedge sys_clk);
    wb_adr = 32'h0000_3000; wb_we = 0; wb_sel = 4'hF; wb_cyc = 1; wb_stb = 1; mem_rdy = 0;
    @(posedge sys_clk); @(negedge sys_clk);
    chk("rst.req_before", 32'(mem_req), 32'd1);
    #2 reset_n = 0;
    #1 chk("rst.req_drop", 32'(mem_req), 32'd0);
    acks = 0;
    repeat (3) begin @(negedge sys_clk); acks += 32'(wb_ack); end
    wb_cyc = 0; wb_stb = 0;
    @(negedge sys_clk); reset_n = 1;
    repeat (4) begin @(negedge sys_clk); acks += 32'(wb_ack) + 32'(mem_req); end
    chk("rst.no_ack", acks, 0);
    chk("rst.flags", {30'h0, err_timeout, err_unmapped}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
